rob_multiport: RTL and testbench
================================

Name: rob_multiport

Overview:
Parametrised reorder buffer. Entries are allocated in program order by the Dispatcher and filled with results from CDB_PORTS independent result buses. The head entry commits in order, at most one per cycle. On commit the block writes the register file, notifies the branch predictor, releases stores to the LSB, and triggers a flush with the correct redirect PC on a branch or JALR mispredict. Two combinational operand-query ports, with same-cycle CDB bypass, let the Dispatcher read values from in-flight entries.

Parameters:
ROB_WIDTH, 3, log2 of entry count.
ROB_SIZE, 1<<ROB_WIDTH, entry count.
CDB_PORTS, 2, number of result buses (≥1).

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low = freeze all state and outputs
new_entry_en  in  1  allocate tail entry
new_entry_type  in  2  0 REGISTER, 1 BRANCH, 2 JALR, 3 STORE
new_entry_rd  in  5  destination register
new_entry_pc  in  32  instruction PC
new_entry_target  in  32  BRANCH: taken target; JALR: predicted target
new_entry_predict  in  1  BRANCH predicted taken
new_entry_ready  in  1  result already known at dispatch
new_entry_data  in  32  result when new_entry_ready
cdb_en  in  CDB_PORTS  per-port valid
cdb_idx  in  CDB_PORTS*ROB_WIDTH  per-port entry index (port k at [k*W +: W])
cdb_data  in  CDB_PORTS*32  per-port result
query_idx_a, query_idx_b  in  ROB_WIDTH  operand lookup index
query_ready_a, query_ready_b  out  1  entry result available
query_data_a, query_data_b  out  32  entry result
full  out  1  count == ROB_SIZE
empty  out  1  count == 0
tail_idx  out  ROB_WIDTH  index the next allocation receives
rf_we  out  1  RF write pulse
rf_rd  out  5  RF destination
rf_idx  out  ROB_WIDTH  committing entry index (RF clears tag if matching)
rf_data  out  32  RF write value
store_commit_en  out  1  pulse: LSB may perform store
store_commit_idx  out  ROB_WIDTH  store entry index
bp_en  out  1  predictor update pulse
bp_pc  out  32  branch PC
bp_taken  out  1  actual outcome
flush  out  1  pulse: mispredict, all units discard state
redirect_pc  out  32  fetch PC, valid with flush

Behaviour:
- Reset: head=tail=count=0; all busy/ready bits 0; every output register 0 (rf_we, store_commit_en, bp_en, flush, rf_rd, rf_idx, rf_data, store_commit_idx, bp_pc, bp_taken, redirect_pc). empty=1, full=0.
- Occupancy uses a (ROB_WIDTH+1)-bit count. Pointers wrap modulo ROB_SIZE. full/empty derive from the registered count only.
- Allocate when new_entry_en && !full && !flush. Entry takes the fields; ready=new_entry_ready. tail++.
- If full, the allocation is dropped even when a commit happens the same cycle.
- CDB: for each port k with cdb_en[k] and a busy target entry: ready=1, data=cdb_data[k]. Writes to non-busy entries are ignored. Same index on two ports: the lowest k wins.
- Query (combinational): ready/data come from the entry. If any cdb port targets that index this cycle, report ready=1 with the lowest-k cdb data. A non-busy entry reports ready=0.
- Commit: if the head entry is busy and ready (registered state; a same-cycle CDB write is not seen) and flush=0, then pop: head++, count--. Outputs are registered and visible next cycle for exactly 1 cycle.
  - REGISTER: rf_we=1, rf_rd=rd, rf_idx=head, rf_data=data.
  - STORE: store_commit_en=1, store_commit_idx=head.
  - BRANCH: bp_en=1, bp_pc=pc, bp_taken=data[0]. If data[0]!=predict: flush=1, redirect_pc = data[0] ? target : pc+4.
  - JALR: rf_we=1, rf_data=pc+4. If data!=target: flush=1, redirect_pc=data.
- Latency: a CDB write in cycle t allows commit at edge t+1, with outputs high in cycle t+2. new_entry_ready gives allocate at t, commit at t+1.
- Mispredict commit: at the same edge all busy/ready bits clear and head=tail=count=0. Younger entries never commit. In the cycle flush is high, allocation, CDB writes and commit are all ignored.
- Allocate + commit in the same cycle: count unchanged.
- Allocate + CDB writing the same index in the same cycle: the CDB write is ignored.
- rdy_in=0: no state or output changes, pulses held.
- rst_in overrides everything; reset in mid-flush clears flush.

Test Plan:
- Reset, then 8 REGISTER allocs (ROB_WIDTH=3) -> full=1 after 8th. 9th alloc is dropped; tail_idx=0.
- Fill, CDB ports 0/1 in the same cycle write idx 1 (0x11) and idx 0 (0x22) -> commits idx0 then idx1 on consecutive cycles: rf_data 0x22, then 0x11; rf_idx 0,1.
- Both CDB ports target idx 2 with 0xA/0xB -> query_data_a(idx2)=0xA same cycle; committed value 0xA.
- BRANCH pc=0x100, target=0x200, predict=0, CDB data=1 -> bp_en, bp_taken=1, flush=1, redirect_pc=0x200. The next-cycle allocation is ignored, then empty=1.
- JALR pc=0x40, target=0x80, CDB data=0x80 -> rf_data=0x44 and no flush. Repeat with data 0x90 -> flush, redirect_pc=0x90.
- Wrap-around: 20 alloc/commit pairs interleaved with rdy_in low for 3 cycles mid-stream -> in-order rf_idx 0..7,0..; no outputs change while rdy_in=0; count never exceeds 8.

Source files
------------

// File: rtl/rob_multiport.sv
// Reorder buffer: in-order allocate, out-of-order fill from CDB_PORTS result buses, in-order commit (max 1/cycle).
// Commit outputs are registered (1-cycle pulses); rdy_in low freezes all state; allocation is dropped when full.
module rob_multiport #(
  parameter int ROB_WIDTH = 3,
  parameter int ROB_SIZE  = 1 << ROB_WIDTH,
  parameter int CDB_PORTS = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           new_entry_en,
  input  logic [1:0]                     new_entry_type,
  input  logic [4:0]                     new_entry_rd,
  input  logic [31:0]                    new_entry_pc,
  input  logic [31:0]                    new_entry_target,
  input  logic                           new_entry_predict,
  input  logic                           new_entry_ready,
  input  logic [31:0]                    new_entry_data,
  input  logic [CDB_PORTS-1:0]           cdb_en,
  input  logic [CDB_PORTS*ROB_WIDTH-1:0] cdb_idx,
  input  logic [CDB_PORTS*32-1:0]        cdb_data,
  input  logic [ROB_WIDTH-1:0]           query_idx_a,
  input  logic [ROB_WIDTH-1:0]           query_idx_b,
  output logic                           query_ready_a,
  output logic                           query_ready_b,
  output logic [31:0]                    query_data_a,
  output logic [31:0]                    query_data_b,
  output logic                           full,
  output logic                           empty,
  output logic [ROB_WIDTH-1:0]           tail_idx,
  output logic                           rf_we,
  output logic [4:0]                     rf_rd,
  output logic [ROB_WIDTH-1:0]           rf_idx,
  output logic [31:0]                    rf_data,
  output logic                           store_commit_en,
  output logic [ROB_WIDTH-1:0]           store_commit_idx,
  output logic                           bp_en,
  output logic [31:0]                    bp_pc,
  output logic                           bp_taken,
  output logic                           flush,
  output logic [31:0]                    redirect_pc
);

  typedef enum logic [1:0] {
    T_REGISTER = 2'd0,
    T_BRANCH   = 2'd1,
    T_JALR     = 2'd2,
    T_STORE    = 2'd3
  } entry_type_e;

  typedef struct packed {
    entry_type_e typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] target;
    logic        predict;
    logic [31:0] data;
  } entry_t;

  entry_t                 ent [ROB_SIZE];
  logic [ROB_SIZE-1:0]    busy;
  logic [ROB_SIZE-1:0]    ready;
  logic [ROB_WIDTH-1:0]   head;
  logic [ROB_WIDTH-1:0]   tail;
  logic [ROB_WIDTH:0]     count;

  logic                   cdb_hit [ROB_SIZE];
  logic [31:0]            cdb_val [ROB_SIZE];

  entry_t                 head_ent;
  logic                   do_alloc;
  logic                   do_commit;
  logic                   br_taken;
  logic                   mispredict;

  assign full     = (count == (ROB_WIDTH+1)'(ROB_SIZE));
  assign empty    = (count == '0);
  assign tail_idx = tail;

  assign head_ent  = ent[head];
  assign do_alloc  = new_entry_en && !full && !flush;
  assign do_commit = busy[head] && ready[head] && !flush;
  assign br_taken  = head_ent.data[0];

  always_comb begin
    mispredict = 1'b0;
    if (do_commit) begin
      if (head_ent.typ == T_BRANCH)
        mispredict = (br_taken != head_ent.predict);
      else if (head_ent.typ == T_JALR)
        mispredict = (head_ent.data != head_ent.target);
    end
  end

  // Per-entry CDB resolution; scanning high to low lets the lowest port win.
  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      cdb_hit[i] = 1'b0;
      cdb_val[i] = '0;
      for (int k = CDB_PORTS - 1; k >= 0; k--) begin
        if (cdb_en[k] && (cdb_idx[k*ROB_WIDTH +: ROB_WIDTH] == ROB_WIDTH'(i))) begin
          cdb_hit[i] = 1'b1;
          cdb_val[i] = cdb_data[k*32 +: 32];
        end
      end
    end
  end

  always_comb begin
    query_ready_a = busy[query_idx_a] && (cdb_hit[query_idx_a] || ready[query_idx_a]);
    query_data_a  = cdb_hit[query_idx_a] ? cdb_val[query_idx_a] : ent[query_idx_a].data;
    query_ready_b = busy[query_idx_b] && (cdb_hit[query_idx_b] || ready[query_idx_b]);
    query_data_b  = cdb_hit[query_idx_b] ? cdb_val[query_idx_b] : ent[query_idx_b].data;
  end

  // Payload storage needs no reset: busy/ready qualify every use.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !flush) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (busy[i] && cdb_hit[i])
          ent[i].data <= cdb_val[i];
      end
      if (do_alloc) begin
        ent[tail].typ     <= entry_type_e'(new_entry_type);
        ent[tail].rd      <= new_entry_rd;
        ent[tail].pc      <= new_entry_pc;
        ent[tail].target  <= new_entry_target;
        ent[tail].predict <= new_entry_predict;
        ent[tail].data    <= new_entry_data;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      busy             <= '0;
      ready            <= '0;
      rf_we            <= 1'b0;
      rf_rd            <= '0;
      rf_idx           <= '0;
      rf_data          <= '0;
      store_commit_en  <= 1'b0;
      store_commit_idx <= '0;
      bp_en            <= 1'b0;
      bp_pc            <= '0;
      bp_taken         <= 1'b0;
      flush            <= 1'b0;
      redirect_pc      <= '0;
    end else if (rdy_in) begin
      rf_we           <= 1'b0;
      store_commit_en <= 1'b0;
      bp_en           <= 1'b0;
      flush           <= 1'b0;
      if (!flush) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          if (busy[i] && cdb_hit[i])
            ready[i] <= 1'b1;
        end
        if (do_alloc) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= new_entry_ready;
          tail        <= tail + ROB_WIDTH'(1);
        end
        if (do_commit) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + ROB_WIDTH'(1);
          case (head_ent.typ)
            T_REGISTER: begin
              rf_we   <= 1'b1;
              rf_rd   <= head_ent.rd;
              rf_idx  <= head;
              rf_data <= head_ent.data;
            end
            T_STORE: begin
              store_commit_en  <= 1'b1;
              store_commit_idx <= head;
            end
            T_BRANCH: begin
              bp_en       <= 1'b1;
              bp_pc       <= head_ent.pc;
              bp_taken    <= br_taken;
              redirect_pc <= br_taken ? head_ent.target : head_ent.pc + 32'd4;
            end
            default: begin
              rf_we       <= 1'b1;
              rf_rd       <= head_ent.rd;
              rf_idx      <= head;
              rf_data     <= head_ent.pc + 32'd4;
              redirect_pc <= head_ent.data;
            end
          endcase
        end
        count <= count + (ROB_WIDTH+1)'(do_alloc) - (ROB_WIDTH+1)'(do_commit);
        // A mispredict squashes everything younger, including this cycle's allocation.
        if (mispredict) begin
          busy  <= '0;
          ready <= '0;
          head  <= '0;
          tail  <= '0;
          count <= '0;
          flush <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: directed vectors, queue-based reference model checked every cycle, literal spot checks.
module tb_rob_multiport;
  localparam int W = 3;
  localparam int N = 8;
  localparam int P = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rdy;
  logic          new_entry_en;
  logic [1:0]    new_entry_type;
  logic [4:0]    new_entry_rd;
  logic [31:0]   new_entry_pc, new_entry_target, new_entry_data;
  logic          new_entry_predict, new_entry_ready;
  logic [P-1:0]  cdb_en;
  logic [P*W-1:0] cdb_idx;
  logic [P*32-1:0] cdb_data;
  logic [W-1:0]  query_idx_a, query_idx_b;
  logic          query_ready_a, query_ready_b;
  logic [31:0]   query_data_a, query_data_b;
  logic          full, empty;
  logic [W-1:0]  tail_idx;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [W-1:0]  rf_idx;
  logic [31:0]   rf_data;
  logic          store_commit_en;
  logic [W-1:0]  store_commit_idx;
  logic          bp_en;
  logic [31:0]   bp_pc;
  logic          bp_taken;
  logic          flush;
  logic [31:0]   redirect_pc;

  rob_multiport #(.ROB_WIDTH(W), .CDB_PORTS(P)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .new_entry_en(new_entry_en), .new_entry_type(new_entry_type), .new_entry_rd(new_entry_rd),
    .new_entry_pc(new_entry_pc), .new_entry_target(new_entry_target),
    .new_entry_predict(new_entry_predict), .new_entry_ready(new_entry_ready),
    .new_entry_data(new_entry_data),
    .cdb_en(cdb_en), .cdb_idx(cdb_idx), .cdb_data(cdb_data),
    .query_idx_a(query_idx_a), .query_idx_b(query_idx_b),
    .query_ready_a(query_ready_a), .query_ready_b(query_ready_b),
    .query_data_a(query_data_a), .query_data_b(query_data_b),
    .full(full), .empty(empty), .tail_idx(tail_idx),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_idx(rf_idx), .rf_data(rf_data),
    .store_commit_en(store_commit_en), .store_commit_idx(store_commit_idx),
    .bp_en(bp_en), .bp_pc(bp_pc), .bp_taken(bp_taken),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  int qcnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the ROB is a queue of in-flight instructions, oldest first.
  typedef struct {
    int          idx;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] target;
    logic        predict;
    logic        rdy;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  ment_t       mh;
  int          mtail = 0;
  int          m_sz;
  bit          m_com, m_miss, m_found;
  logic        e_rf_we = 0, e_st_en = 0, e_bp_en = 0, e_flush = 0, e_bp_taken = 0;
  logic [4:0]  e_rf_rd = 0;
  logic [W-1:0] e_rf_idx = 0, e_st_idx = 0;
  logic [31:0] e_rf_data = 0, e_bp_pc = 0, e_redirect = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mtail = 0;
      e_rf_we = 0; e_st_en = 0; e_bp_en = 0; e_flush = 0; e_bp_taken = 0;
      e_rf_rd = 0; e_rf_idx = 0; e_st_idx = 0; e_rf_data = 0; e_bp_pc = 0; e_redirect = 0;
    end else if (rdy) begin
      if (e_flush) begin
        e_rf_we = 0; e_st_en = 0; e_bp_en = 0; e_flush = 0;
      end else begin
        e_rf_we = 0; e_st_en = 0; e_bp_en = 0;
        m_sz   = mq.size();
        m_com  = (m_sz > 0) && mq[0].rdy;
        m_miss = 0;
        foreach (mq[j]) begin
          m_found = 0;
          for (int k = 0; k < P; k++)
            if (!m_found && cdb_en[k] && int'(cdb_idx[k*W +: W]) == mq[j].idx) begin
              m_found = 1;
              mq[j].rdy = 1;
              mq[j].data = cdb_data[k*32 +: 32];
            end
        end
        if (m_com) begin
          mh = mq.pop_front();
          if (mh.typ == 2'd0) begin
            e_rf_we = 1; e_rf_rd = mh.rd; e_rf_idx = W'(mh.idx); e_rf_data = mh.data;
          end else if (mh.typ == 2'd3) begin
            e_st_en = 1; e_st_idx = W'(mh.idx);
          end else if (mh.typ == 2'd1) begin
            e_bp_en = 1; e_bp_pc = mh.pc; e_bp_taken = mh.data[0];
            if (mh.data[0] != mh.predict) begin
              m_miss = 1;
              e_redirect = mh.data[0] ? mh.target : mh.pc + 4;
            end
          end else begin
            e_rf_we = 1; e_rf_rd = mh.rd; e_rf_idx = W'(mh.idx); e_rf_data = mh.pc + 4;
            if (mh.data != mh.target) begin
              m_miss = 1;
              e_redirect = mh.data;
            end
          end
        end
        if (m_miss) begin
          mq.delete();
          mtail = 0;
          e_flush = 1;
        end else if (new_entry_en && m_sz < N) begin
          mq.push_back('{idx: mtail, typ: new_entry_type, rd: new_entry_rd, pc: new_entry_pc,
                         target: new_entry_target, predict: new_entry_predict,
                         rdy: new_entry_ready, data: new_entry_data});
          mtail = (mtail + 1) % N;
        end
      end
    end
  end

  function automatic void mquery(input logic [W-1:0] qi, output logic r, output logic [31:0] d);
    bit hit;
    r = 0; d = 0; hit = 0;
    foreach (mq[j]) if (mq[j].idx == int'(qi)) begin
      r = mq[j].rdy; d = mq[j].data;
      for (int k = 0; k < P; k++)
        if (!hit && cdb_en[k] && cdb_idx[k*W +: W] == qi) begin
          hit = 1; r = 1; d = cdb_data[k*32 +: 32];
        end
    end
  endfunction

  logic        m_qr;
  logic [31:0] m_qd;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("full", 32'(full), 32'(mq.size() == N));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("tail_idx", 32'(tail_idx), 32'(mtail));
      chk("rf_we", 32'(rf_we), 32'(e_rf_we));
      chk("store_commit_en", 32'(store_commit_en), 32'(e_st_en));
      chk("bp_en", 32'(bp_en), 32'(e_bp_en));
      chk("flush", 32'(flush), 32'(e_flush));
      if (e_rf_we) begin
        chk("rf_rd", 32'(rf_rd), 32'(e_rf_rd));
        chk("rf_idx", 32'(rf_idx), 32'(e_rf_idx));
        chk("rf_data", rf_data, e_rf_data);
      end
      if (e_st_en) chk("store_commit_idx", 32'(store_commit_idx), 32'(e_st_idx));
      if (e_bp_en) begin
        chk("bp_pc", bp_pc, e_bp_pc);
        chk("bp_taken", 32'(bp_taken), 32'(e_bp_taken));
      end
      if (e_flush) chk("redirect_pc", redirect_pc, e_redirect);
      mquery(query_idx_a, m_qr, m_qd);
      chk("query_ready_a", 32'(query_ready_a), 32'(m_qr));
      if (m_qr) chk("query_data_a", query_data_a, m_qd);
      mquery(query_idx_b, m_qr, m_qd);
      chk("query_ready_b", 32'(query_ready_b), 32'(m_qr));
      if (m_qr) chk("query_data_b", query_data_b, m_qd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    query_idx_a = W'(qcnt);
    query_idx_b = W'(qcnt + 5);
    qcnt++;
  endtask

  task automatic idle();
    new_entry_en = 0;
    cdb_en = '0;
  endtask

  task automatic set_alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                           input logic [31:0] tg, input logic pr, input logic rr, input logic [31:0] d);
    new_entry_en = 1; new_entry_type = t; new_entry_rd = rd; new_entry_pc = pc;
    new_entry_target = tg; new_entry_predict = pr; new_entry_ready = rr; new_entry_data = d;
  endtask

  task automatic set_cdb(input int k, input logic [W-1:0] idx, input logic [31:0] d);
    cdb_en[k] = 1'b1;
    cdb_idx[k*W +: W] = idx;
    cdb_data[k*32 +: 32] = d;
  endtask

  initial begin
    rst = 1; rdy = 1;
    new_entry_en = 0; new_entry_type = 0; new_entry_rd = 0; new_entry_pc = 0;
    new_entry_target = 0; new_entry_predict = 0; new_entry_ready = 0; new_entry_data = 0;
    cdb_en = '0; cdb_idx = '0; cdb_data = '0;
    query_idx_a = 0; query_idx_b = 0;
    step();
    chk_on = 1;
    step();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_tail", 32'(tail_idx), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    rst = 0;

    // Fill to capacity, then one dropped allocation.
    for (int i = 0; i < N; i++) begin
      set_alloc(2'd0, 5'(i + 1), 32'h1000 + 32'(4 * i), 0, 0, 0, 0);
      step();
    end
    chk("full_after_8", 32'(full), 32'd1);
    step();
    idle();
    chk("drop_tail", 32'(tail_idx), 32'd0);
    chk("drop_full", 32'(full), 32'd1);

    // Two ports in one cycle, out of order.
    set_cdb(0, 3'd1, 32'h11);
    set_cdb(1, 3'd0, 32'h22);
    step(); idle(); step();
    chk("c0_rf_we", 32'(rf_we), 32'd1);
    chk("c0_rf_idx", 32'(rf_idx), 32'd0);
    chk("c0_rf_data", rf_data, 32'h22);
    step();
    chk("c1_rf_idx", 32'(rf_idx), 32'd1);
    chk("c1_rf_data", rf_data, 32'h11);

    // Both ports on idx 2: port 0 wins, visible through the query bypass.
    set_cdb(0, 3'd2, 32'hA);
    set_cdb(1, 3'd2, 32'hB);
    query_idx_a = 3'd2;
    #1;
    chk("q_bypass_ready", 32'(query_ready_a), 32'd1);
    chk("q_bypass_data", query_data_a, 32'hA);
    step(); idle(); step();
    chk("c2_rf_idx", 32'(rf_idx), 32'd2);
    chk("c2_rf_data", rf_data, 32'hA);

    for (int i = 3; i < N; i++) begin
      idle();
      set_cdb(0, W'(i), 32'h100 + 32'(i));
      step();
    end
    idle();
    repeat (3) step();
    chk("drained_empty", 32'(empty), 32'd1);

    // Branch mispredict squashes a younger ready entry.
    set_alloc(2'd1, 5'd0, 32'h100, 32'h200, 0, 0, 0);
    step();
    set_alloc(2'd0, 5'd5, 32'h104, 0, 0, 1, 32'h55);
    step(); idle();
    set_cdb(0, 3'd0, 32'd1);
    step(); idle(); step();
    chk("br_bp_en", 32'(bp_en), 32'd1);
    chk("br_taken", 32'(bp_taken), 32'd1);
    chk("br_pc", bp_pc, 32'h100);
    chk("br_flush", 32'(flush), 32'd1);
    chk("br_redirect", redirect_pc, 32'h200);
    set_alloc(2'd0, 5'd6, 32'h108, 0, 0, 1, 32'h66);
    step(); idle();
    chk("br_after_empty", 32'(empty), 32'd1);
    chk("br_after_flush", 32'(flush), 32'd0);
    chk("br_after_tail", 32'(tail_idx), 32'd0);
    step();
    chk("br_squashed", 32'(rf_we), 32'd0);

    // JALR: correct then mispredicted target.
    set_alloc(2'd2, 5'd3, 32'h40, 32'h80, 0, 0, 0);
    step(); idle();
    set_cdb(0, 3'd0, 32'h80);
    step(); idle(); step();
    chk("jalr_rf_we", 32'(rf_we), 32'd1);
    chk("jalr_rf_data", rf_data, 32'h44);
    chk("jalr_no_flush", 32'(flush), 32'd0);
    set_alloc(2'd2, 5'd4, 32'h40, 32'h80, 0, 0, 0);
    step(); idle();
    set_cdb(0, 3'd1, 32'h90);
    step(); idle(); step();
    chk("jalr2_flush", 32'(flush), 32'd1);
    chk("jalr2_redirect", redirect_pc, 32'h90);
    chk("jalr2_rf_data", rf_data, 32'h44);
    step();

    // Wrap-around stream with a 3-cycle freeze.
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        rdy = 0;
        set_alloc(2'd0, 5'd1, 32'h2000, 0, 0, 1, 32'd99);
        repeat (3) begin
          step();
          chk("frz_rf_we", 32'(rf_we), 32'd1);
          chk("frz_rf_idx", 32'(rf_idx), 32'd0);
          chk("frz_rf_data", rf_data, 32'd8);
        end
        rdy = 1;
      end
      set_alloc(2'd0, 5'((i % 31) + 1), 32'h2000 + 32'(4 * i), 0, 0, 1, 32'(i));
      step();
      if (i > 0) begin
        chk("wrap_rf_we", 32'(rf_we), 32'd1);
        chk("wrap_rf_idx", 32'(rf_idx), 32'((i - 1) % 8));
        chk("wrap_rf_data", rf_data, 32'(i - 1));
      end
    end
    idle();
    repeat (3) step();
    chk("end_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
